// File: rtl/key_evt_pkg.sv
// Shared types for the key gesture decoder: FSM states and event codes.
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        HOLD,
        WAIT_REL
    } state_t;

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_DOUBLE = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

endpackage

// File: rtl/key_gesture_decoder.sv
// Turns debounced press pulses and key level into SHORT / DOUBLE / LONG / REPEAT
// event strobes, using one FSM and a single shared terminal-count counter.
module key_gesture_decoder
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT   = 1000,
    parameter int DCLK_CNT   = 500,
    parameter int REPEAT_CNT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pulse,
    input  logic       key_state,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       busy
);

    localparam int MAX_LD  = (LONG_CNT > DCLK_CNT) ? LONG_CNT : DCLK_CNT;
    localparam int MAX_CNT = (MAX_LD > REPEAT_CNT) ? MAX_LD : REPEAT_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLK_LAST   = CNT_W'(DCLK_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_evt_valid;
    logic [1:0]       r_evt_code;
    logic             r_busy;
    logic             w_emit;
    logic [1:0]       w_code;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_emit       = 1'b0;
        w_code       = r_evt_code;

        unique case (r_state)
            IDLE: begin
                if (key_pulse) begin
                    w_next_state = PRESS1;
                    w_next_cnt   = CNT_ZERO;
                end
            end
            PRESS1: begin
                // Release wins over the long threshold on the same edge.
                if (key_state) begin
                    w_next_state = GAP;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == LONG_LAST) begin
                    w_emit       = 1'b1;
                    w_code       = EVT_LONG;
                    w_next_state = HOLD;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (key_pulse) begin
                    w_emit       = 1'b1;
                    w_code       = EVT_DOUBLE;
                    w_next_state = WAIT_REL;
                end else if (r_cnt == DCLK_LAST) begin
                    w_emit       = 1'b1;
                    w_code       = EVT_SHORT;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (key_state) begin
                    w_next_state = IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_emit     = 1'b1;
                    w_code     = EVT_REPEAT;
                    w_next_cnt = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            WAIT_REL: begin
                if (key_state) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = CNT_ZERO;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= CNT_ZERO;
            r_evt_valid <= 1'b0;
            r_evt_code  <= EVT_SHORT;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_evt_valid <= w_emit;
            r_busy      <= (w_next_state != IDLE);
            if (w_emit) begin
                r_evt_code <= w_code;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;
    assign busy      = r_busy;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// Directed bench for key_gesture_decoder: expected events are queued with the edge
// they must follow, and a monitor compares every strobe against the queue.
module tb_key_gesture_decoder;

    localparam int LONG_CNT   = 20;
    localparam int DCLK_CNT   = 10;
    localparam int REPEAT_CNT = 8;

    localparam logic [1:0] C_SHORT  = 2'd0;
    localparam logic [1:0] C_DOUBLE = 2'd1;
    localparam logic [1:0] C_LONG   = 2'd2;
    localparam logic [1:0] C_REPEAT = 2'd3;

    typedef struct {
        logic [1:0] code;
        int         edge_n;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       key_pulse;
    logic       key_state;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       busy;

    int   edge_no   = 0;
    int   tests_run = 0;
    int   fails     = 0;
    exp_t sb_q[$];

    key_gesture_decoder #(
        .LONG_CNT  (LONG_CNT),
        .DCLK_CNT  (DCLK_CNT),
        .REPEAT_CNT(REPEAT_CNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_pulse(key_pulse),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [1:0] code, input int edge_n);
        exp_t e;
        e.code   = code;
        e.edge_n = edge_n;
        sb_q.push_back(e);
    endtask

    // Returns the edge number P that sampled the pulse.
    task automatic press(output int p);
        key_pulse = 1'b1;
        key_state = 1'b0;
        tick(1);
        p = edge_no;
        key_pulse = 1'b0;
    endtask

    task automatic release_key(output int r);
        key_state = 1'b1;
        tick(1);
        r = edge_no;
    endtask

    // Monitor: half a cycle after each edge, an expected entry due at this edge must
    // be strobing with its code; any other strobe is unexpected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() > 0 && sb_q[0].edge_n == edge_no) begin
                check("evt_valid_due", int'(evt_valid), 1);
                check("evt_code", int'(evt_code), int'(sb_q[0].code));
                void'(sb_q.pop_front());
            end else if (evt_valid) begin
                check("unexpected_evt", int'(evt_valid), 0);
            end
        end
    end

    initial begin
        int p;
        int r;

        rst_n     = 1'b0;
        key_pulse = 1'b0;
        key_state = 1'b1;
        tick(20);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_code", int'(evt_code), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(3);

        // Short press: held 5 cycles, SHORT after R+10.
        press(p);
        check("short_busy_rise", int'(busy), 1);
        tick(5);
        release_key(r);
        expect_evt(C_SHORT, r + DCLK_CNT);
        tick(DCLK_CNT - 1);
        check("short_busy_before", int'(busy), 1);
        tick(1);
        check("short_busy_fall", int'(busy), 0);
        tick(5);

        // Double click: second pulse 4 edges after release, then long hold.
        press(p);
        tick(5);
        release_key(r);
        tick(3);
        expect_evt(C_DOUBLE, r + 4);
        press(p);
        check("dbl_edge", p, r + 4);
        tick(50);
        check("dbl_busy_held", int'(busy), 1);
        release_key(r);
        check("dbl_busy_fall", int'(busy), 0);
        check("dbl_code_hold", int'(evt_code), int'(C_DOUBLE));
        tick(5);

        // Long press with repeats, held 45 edges after P.
        press(p);
        expect_evt(C_LONG, p + LONG_CNT);
        for (int k = 1; k <= 3; k++) expect_evt(C_REPEAT, p + LONG_CNT + k * REPEAT_CNT);
        tick(45);
        check("long_busy_held", int'(busy), 1);
        release_key(r);
        check("long_busy_fall", int'(busy), 0);
        check("long_code_hold", int'(evt_code), int'(C_REPEAT));
        tick(15);

        // Boundary: release sampled exactly at P+LONG_CNT takes the GAP path.
        press(p);
        tick(LONG_CNT - 1);
        release_key(r);
        check("bnd_rel_edge", r, p + LONG_CNT);
        expect_evt(C_SHORT, r + DCLK_CNT);
        tick(DCLK_CNT + 5);
        check("bnd_rel_busy", int'(busy), 0);

        // Boundary: second pulse exactly at R+DCLK_CNT gives DOUBLE only.
        press(p);
        tick(5);
        release_key(r);
        tick(DCLK_CNT - 1);
        expect_evt(C_DOUBLE, r + DCLK_CNT);
        press(p);
        check("bnd_dbl_edge", p, r + DCLK_CNT);
        tick(4);
        release_key(r);
        check("bnd_dbl_busy", int'(busy), 0);
        tick(5);

        // Reset mid-gesture in PRESS1 with cnt=5: outputs clear at once, no event after.
        press(p);
        tick(5);
        check("mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_evt_valid", int'(evt_valid), 0);
        check("mid_rst_evt_code", int'(evt_code), 0);
        check("mid_rst_busy", int'(busy), 0);
        key_state = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(30);
        check("post_rst_busy", int'(busy), 0);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/key_gesture_decoder.md
# key_gesture_decoder

Classifies debounced push-button activity into discrete gesture events: short press, double click, long press and auto-repeat. It sits directly downstream of `debounce`, consuming its `key_pulse`/`key_state` outputs. It presents one registered event strobe with a 2-bit code to application logic such as menu control or mode selection.

## Interface
- `LONG_CNT`, default 1000: number of held clock cycles after the press pulse that classifies a press as long. Must be ≥ 2.
- `DCLK_CNT`, default 500: maximum release-to-press gap, in cycles, that still counts as a double click. Must be ≥ 2.
- `REPEAT_CNT`, default 200: period, in cycles, of repeat events while a long press is held. Must be ≥ 2.
- `clk` input 1: system clock. The block uses one clock only.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `key_pulse` input 1: one-cycle high strobe on a debounced press.
- `key_state` input 1: debounced key level. 0 means pressed, 1 means released.
- `evt_valid` output 1: one-cycle event strobe.
- `evt_code` output 2: event type, valid only while `evt_valid` is high. 0 = SHORT, 1 = DOUBLE, 2 = LONG, 3 = REPEAT.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- A single counter `cnt` is shared by all timing. Its width is `$clog2(max(LONG_CNT,DCLK_CNT,REPEAT_CNT))`.
- All outputs are registered.
- States and transitions, evaluated at each rising edge:
  - **IDLE**: if `key_pulse`, go to PRESS1 with `cnt`=0. Otherwise stay.
  - **PRESS1**: if `key_state`=1, go to GAP with `cnt`=0. This check takes priority over the long-press threshold. Otherwise, if `cnt`=LONG_CNT-1, emit LONG and go to HOLD with `cnt`=0. Otherwise increment `cnt`.
  - **GAP**: if `key_pulse`, emit DOUBLE and go to WAIT_REL. This takes priority over timeout. Otherwise, if `cnt`=DCLK_CNT-1, emit SHORT and go to IDLE. Otherwise increment `cnt`.
  - **HOLD**: if `key_state`=1, go to IDLE with no event. Otherwise, if `cnt`=REPEAT_CNT-1, emit REPEAT and set `cnt`=0. Otherwise increment `cnt`.
  - **WAIT_REL**: if `key_state`=1, go to IDLE. A second press never produces LONG or REPEAT.
- `key_pulse` is ignored in PRESS1, HOLD and WAIT_REL.
- At most one event is emitted per cycle.
- "Emit X" means `evt_valid`=1 and `evt_code`=X in the cycle after that edge. In every other cycle `evt_valid`=0.
- `evt_code` holds its last value while `evt_valid`=0.
- Reset, including assertion mid-gesture: the state goes immediately to IDLE and `cnt` to 0. No event is emitted for the aborted gesture.

## Timing
- Reset values: `evt_valid`=0, `evt_code`=0, `busy`=0, state IDLE, `cnt`=0.
- Latencies are counted in edges, where edge P is the edge that samples `key_pulse`.
  - LONG: `evt_valid` is high after edge P+LONG_CNT, provided `key_state`=0 was sampled at edges P+1 through P+LONG_CNT.
  - REPEAT: follows every REPEAT_CNT edges after LONG while the key stays held.
  - SHORT: with the release first sampled at edge R, SHORT is emitted after edge R+DCLK_CNT, unless `key_pulse` was sampled at edges R+1 through R+DCLK_CNT.
  - DOUBLE: emitted in the cycle after the edge that samples the second `key_pulse`.
- `busy` rises the cycle after edge P. It falls the cycle after the edge that returns the FSM to IDLE, which is the same edge that emits SHORT.
- Boundary cases:
  - Release sampled at edge P+LONG_CNT takes the GAP path; no LONG is emitted.
  - `key_pulse` at edge R+DCLK_CNT yields DOUBLE, not SHORT.

## Structure
- Package `key_evt_pkg` holds:
  - the state enum typedef (IDLE, PRESS1, GAP, HOLD, WAIT_REL);
  - the event code constants EVT_SHORT, EVT_DOUBLE, EVT_LONG, EVT_REPEAT.
- No sub-module. The block is a single FSM plus the shared terminal-count counter, implemented in one module.

## Test plan
All scenarios use LONG_CNT=20, DCLK_CNT=10, REPEAT_CNT=8, a 10 ns clock and stimulus driven through `debounce`-style pulse/level inputs.
- **Reset**: hold `rst_n` low for 20 cycles, then assert reset while in PRESS1 at `cnt`=5 → all outputs 0 and `busy`=0 immediately; no event for 30 cycles after reset is released.
- **Short press**: pulse at edge P, hold 5 cycles, release at edge R → exactly one SHORT after edge R+10; no other events.
- **Double click**: press 5 cycles, release, second pulse 4 cycles after the release, hold 50 cycles → exactly one DOUBLE the cycle after the second pulse; no SHORT, LONG or REPEAT.
- **Long press with repeat**: hold 45 cycles after P → LONG after edge P+20; REPEAT after P+28, P+36 and P+44; after release, `busy` falls the next cycle; no SHORT.
- **Boundaries**: release at exactly edge P+20 → no LONG, then SHORT 10 edges later. Second pulse at exactly edge R+10 → DOUBLE only.
